load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface. Accepts byte/halfword/word load and store requests from the CPU datapath over a valid/ready handshake, converts byte addresses to word indices, performs read-modify-write for sub-word stores against the word-wide, synchronous-write/asynchronous-read data memory, and returns aligned, sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- ADDR_BITS, 8, word-index width of the attached data memory (2^ADDR_BITS words)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, reserved size or out of range
- mem_addr  out  32  word index = {2'b0, addr[31:2]}
- mem_write  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- Little-endian lanes: byte offset k occupies bits [8k+7:8k]; halfword offset 0 → [15:0], offset 2 → [31:16].
- States: IDLE, READ, WRITE, RESP. req_ready = (state == IDLE).
- IDLE: on handshake latch write, size, signed, addr, wdata. Error if size==11, half with addr[0]=1, word with addr[1:0]≠0, or addr[31:ADDR_BITS+2]≠0 → RESP with err. Else word store → WRITE (merged word = wdata); else → READ.
- READ: mem_write=0, mem_addr driven; sample mem_rdata. Load: extract lane, extend, register into result → RESP. Sub-word store: replace addressed lane(s) of mem_rdata with wdata, register merged word → WRITE.
- WRITE: mem_write=1, mem_wdata=merged word → RESP.
- RESP: resp_valid=1, resp_err and resp_rdata registered → IDLE.
- resp_rdata and resp_err hold their values until the next RESP; resp_valid low outside RESP.
- mem_addr driven from latched address in READ/WRITE; value in IDLE/RESP is don't-care but must be stable (hold latched address).
- mem_write is never 1 outside WRITE, and is forced 0 whenever reset=1.

## Timing
- Handshake edge = cycle 0. resp_valid high in: cycle 1 (error), cycle 2 (load, word store), cycle 3 (byte/half store).
- Memory write commits at the rising edge ending WRITE (cycle 1 word store, cycle 2 sub-word store).
- Next request acceptable the cycle after RESP; no overlap, no pipelining.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_write 0, mem_addr 0, mem_wdata 0.
- Reset at any state: next state IDLE, no response issued for the aborted request; reset during WRITE commits no write (mem_write gated).
- req_valid without ready is ignored; inputs need not be held after the accepting edge.

## Structure
- Shared package lsu_defs: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state encoding, lane-select helpers.
- One combinational sub-module lsu_lane_align: load extract/extend and store merge, given offset, size, signed.
- FSM, request latch and response registers in load_store_unit.

## Test plan
- Word store 0xDEADBEEF at 0x10 → mem_write=1, mem_addr=0x4 in cycle 1, resp cycle 2 err=0; word load 0x10 → resp_rdata 0xDEADBEEF.
- mem[1]=0x11223344; byte store 0xAB at 0x05 → READ cycle 1, WRITE cycle 2 with mem_wdata 0x1122AB44, resp cycle 3.
- mem[1]=0x81A23344; signed byte load 0x06 → 0xFFFFFFA2; unsigned → 0x000000A2; signed half 0x06 → 0xFFFF81A2; unsigned half 0x04 → 0x00003344.
- Word load 0x02, half load 0x01, size=11, load 0x400 → resp cycle 1, err=1, rdata 0, mem_write never 1.
- Reset asserted in WRITE of half store 0xBEEF at 0x04 → no write, mem[1] unchanged, no resp_valid, req_ready=1 next cycle.
- req_valid held with two stores → second accepted the cycle after first resp_valid; both writes land in order.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size and state encodings and
// the lane-mask helper used by the store merge path.
package lsu_defs;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Bits of the memory word touched by an access of the given size/offset.
  function automatic logic [31:0] lane_mask(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 32'h0000_00FF << {off, 3'b000};
      SZ_HALF: lane_mask = 32'h0000_FFFF << {off[1], 4'b0000};
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic misaligned(logic [1:0] sz, logic [1:0] off);
    case (sz)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response and memory-side signals of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write, mem_wdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge
// into the word read back from memory.
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [1:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_mask = lane_mask(i_size, i_offset);

  always_comb begin
    case (i_size)
      SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load = i_rdata;
    endcase
  end

  assign o_merged = (i_rdata & ~w_mask) | ((i_wdata << {i_offset, 3'b000}) & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request latch, IDLE/READ/WRITE/RESP sequencer and
// registered response, driving a word-wide async-read memory.
module load_store_unit
  import lsu_defs::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  state_e      r_state;
  logic        r_write;
  size_e       r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic        r_mem_write;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_req_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_req_err = (bus.req_size == SZ_RSVD)
                   | misaligned(bus.req_size, bus.req_addr[1:0])
                   | (|(bus.req_addr >> (ADDR_BITS + 2)));

  lsu_lane_align u_align (
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_rdata  (bus.mem_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_merged     <= '0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write  <= bus.req_write;
            r_size   <= size_e'(bus.req_size);
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            if (w_req_err) begin
              r_err        <= 1'b1;
              r_rdata      <= '0;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else if (bus.req_write && bus.req_size == SZ_WORD) begin
              r_merged    <= bus.req_wdata;
              r_mem_write <= 1'b1;
              r_state     <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_write) begin
            r_merged    <= w_merged;
            r_mem_write <= 1'b1;
            r_state     <= ST_WRITE;
          end else begin
            r_rdata      <= w_load;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          r_mem_write  <= 1'b0;
          r_rdata      <= '0;
          r_err        <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_addr   = {2'b00, r_addr[31:2]};
  // Gate with reset so a reset landing in WRITE cannot commit at that edge.
  assign bus.mem_write  = r_mem_write & ~reset;
  assign bus.mem_wdata  = r_merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests against a byte-addressed reference memory.
module tb_load_store_unit;
  logic clk;
  logic reset;

  load_store_unit_if lsu_bus ();

  load_store_unit #(.ADDR_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lsu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide data memory attached to the unit, with a preload port for the bench.
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  assign lsu_bus.mem_rdata = (lsu_bus.mem_addr < 32'd256) ? mem[lsu_bus.mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (lsu_bus.mem_write) mem[lsu_bus.mem_addr[7:0]] <= lsu_bus.mem_wdata;
  end

  // Reference: plain byte array, 1 KiB.
  logic [7:0] rb [0:1023];

  int n_checks = 0;
  int n_fail   = 0;
  int op_id    = 0;
  bit after_resp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (op %0d): observed %h expected %h", tag, op_id, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] w);
    ref_word = {rb[{w, 2'd3}], rb[{w, 2'd2}], rb[{w, 2'd1}], rb[{w, 2'd0}]};
  endfunction

  task automatic set_word(input logic [7:0] w, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = w;
    pl_data = d;
    for (int i = 0; i < 4; i++) rb[{w, 2'(i)}] = d[8*i +: 8];
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    after_resp = 1'b0;
  endtask

  task automatic ref_op(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd,
                        output int lat, output int wc);
    int nb;
    logic [9:0] bi;
    nb  = (sz == 2'b11) ? 0 : (1 << sz);
    err = (sz == 2'b11) || (nb > 1 && (a % nb) != 0) || (a >= 32'd1024);
    rd  = 32'h0;
    wc  = 0;
    if (err) begin
      lat = 1;
    end else if (w) begin
      for (int i = 0; i < nb; i++) begin
        bi = a[9:0] + 10'(i);
        rb[bi] = wd[8*i +: 8];
      end
      lat = (nb == 4) ? 2 : 3;
      wc  = (nb == 4) ? 1 : 2;
    end else begin
      for (int i = 0; i < nb; i++) begin
        bi = a[9:0] + 10'(i);
        rd = rd | ({24'h0, rb[bi]} << (8 * i));
      end
      if (sg && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8 * nb));
      lat = 2;
    end
  endtask

  // Issue one request (called #1 after a rising edge), monitor until the
  // response, and check it against the reference model.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wdat, input bit hold,
                        output logic [31:0] rd_o, output logic [31:0] wd_o);
    logic        e_err, er;
    logic [31:0] e_rd, rd, wa, wd;
    int          e_lat, e_wc, lat, wcnt, wcy, waited, cyc;
    op_id++;
    ref_op(w, sz, sg, a, wdat, e_err, e_rd, e_lat, e_wc);
    lsu_bus.req_valid  = 1'b1;
    lsu_bus.req_write  = w;
    lsu_bus.req_size   = sz;
    lsu_bus.req_signed = sg;
    lsu_bus.req_addr   = a;
    lsu_bus.req_wdata  = wdat;
    waited = 0;
    while (!lsu_bus.req_ready && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("accept_wait", 32'(waited), after_resp ? 32'd1 : 32'd0);
    if (after_resp) check("resp_pulse_low", {31'h0, lsu_bus.resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    if (!hold) lsu_bus.req_valid = 1'b0;
    lat = 0; wcnt = 0; wcy = 0; wa = 32'h0; wd = 32'h0; rd = 32'hX; er = 1'bX;
    cyc = 1;
    while (cyc <= 8) begin
      if (lsu_bus.mem_write) begin
        wcnt++;
        wcy = cyc;
        wa  = lsu_bus.mem_addr;
        wd  = lsu_bus.mem_wdata;
      end
      if (lsu_bus.resp_valid) begin
        lat = cyc;
        rd  = lsu_bus.resp_rdata;
        er  = lsu_bus.resp_err;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("resp_err", {31'h0, er}, {31'h0, e_err});
    check("resp_rdata", rd, e_rd);
    check("write_count", 32'(wcnt), (e_wc != 0) ? 32'd1 : 32'd0);
    if (e_wc != 0) begin
      check("write_cycle", 32'(wcy), 32'(e_wc));
      check("write_addr", wa, {24'h0, a[9:2]});
      check("write_data", wd, ref_word(a[9:2]));
      check("mem_word", mem[a[9:2]], ref_word(a[9:2]));
    end
    rd_o = rd;
    wd_o = wd;
    after_resp = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, wd, a;
    logic [1:0]  sz;
    int          bad, r;
    reset = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    lsu_bus.req_valid  = 1'b0;
    lsu_bus.req_write  = 1'b0;
    lsu_bus.req_size   = 2'b00;
    lsu_bus.req_signed = 1'b0;
    lsu_bus.req_addr   = '0;
    lsu_bus.req_wdata  = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) set_word(8'(i), $urandom);

    // Reset values
    check("rst_req_ready", {31'h0, lsu_bus.req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, lsu_bus.resp_valid}, 32'h0);
    check("rst_resp_rdata", lsu_bus.resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, lsu_bus.resp_err}, 32'h0);
    check("rst_mem_write", {31'h0, lsu_bus.mem_write}, 32'h0);
    check("rst_mem_addr", lsu_bus.mem_addr, 32'h0);
    check("rst_mem_wdata", lsu_bus.mem_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    after_resp = 1'b0;

    // Word store then load back
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, wd);
    check("word_store_wdata", wd, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd);
    check("word_load", rd, 32'hDEAD_BEEF);

    // Byte store read-modify-write
    set_word(8'd1, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_00AB, 1'b0, rd, wd);
    check("byte_store_merge", wd, 32'h1122_AB44);

    // Sub-word loads with extension
    set_word(8'd1, 32'h81A2_3344);
    do_req(1'b0, 2'b00, 1'b1, 32'h06, 32'h0, 1'b0, rd, wd);
    check("lb_signed", rd, 32'hFFFF_FFA2);
    do_req(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 1'b0, rd, wd);
    check("lb_unsigned", rd, 32'h0000_00A2);
    do_req(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 1'b0, rd, wd);
    check("lh_signed", rd, 32'hFFFF_81A2);
    do_req(1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 1'b0, rd, wd);
    check("lh_unsigned", rd, 32'h0000_3344);

    // Error cases
    do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b0, rd, wd);
    do_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 1'b0, rd, wd);
    do_req(1'b1, 2'b11, 1'b0, 32'h00, 32'h5555_5555, 1'b0, rd, wd);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0, rd, wd);
    do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF, 1'b0, rd, wd);

    // Reset landing in WRITE of a half store: no commit, no response
    @(posedge clk);
    #1;
    lsu_bus.req_valid = 1'b1;
    lsu_bus.req_write = 1'b1;
    lsu_bus.req_size  = 2'b01;
    lsu_bus.req_signed = 1'b0;
    lsu_bus.req_addr  = 32'h04;
    lsu_bus.req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    lsu_bus.req_valid = 1'b0;
    check("abort_no_resp_c1", {31'h0, lsu_bus.resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("abort_in_write", {31'h0, lsu_bus.mem_write}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_write_gated", {31'h0, lsu_bus.mem_write}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_mem_unchanged", mem[1], ref_word(8'd1));
    check("abort_no_resp", {31'h0, lsu_bus.resp_valid}, 32'h0);
    check("abort_ready", {31'h0, lsu_bus.req_ready}, 32'h1);
    check("abort_rdata_cleared", lsu_bus.resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("abort_no_resp_late", {31'h0, lsu_bus.resp_valid}, 32'h0);
    after_resp = 1'b0;

    // Back-to-back stores with req_valid held
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 1'b1, rd, wd);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_009A, 1'b0, rd, wd);
    check("held_stores_order", mem[8], 32'h1234_9A78);

    // Random traffic
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 9);
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (r == 0) begin
        a = $urandom | 32'h400;
      end else begin
        a = 32'($urandom_range(0, 1023));
        if (r > 3 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, rd, wd);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_word(8'(i))) bad++;
    check("final_mem_mismatches", 32'(bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
